// File: rtl/dm_axi_master_if.sv
// Single-beat AXI4 bus bundle between dm_axi_master and its slave.
interface dm_axi_master_if #(
  parameter int unsigned ID_W = 4
);
  // Read address channel
  logic [ID_W-1:0] ARID;
  logic [31:0]     ARADDR;
  logic [3:0]      ARLEN;
  logic [2:0]      ARSIZE;
  logic [1:0]      ARBURST;
  logic            ARVALID;
  logic            ARREADY;
  // Read data channel
  logic [ID_W-1:0] RID;
  logic [31:0]     RDATA;
  logic [1:0]      RRESP;
  logic            RLAST;
  logic            RVALID;
  logic            RREADY;
  // Write address channel
  logic [ID_W-1:0] AWID;
  logic [31:0]     AWADDR;
  logic [3:0]      AWLEN;
  logic [2:0]      AWSIZE;
  logic [1:0]      AWBURST;
  logic            AWVALID;
  logic            AWREADY;
  // Write data channel
  logic [31:0]     WDATA;
  logic [3:0]      WSTRB;
  logic            WLAST;
  logic            WVALID;
  logic            WREADY;
  // Write response channel
  logic [ID_W-1:0] BID;
  logic [1:0]      BRESP;
  logic            BVALID;
  logic            BREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY,
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY,
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY
  );
endinterface

// File: rtl/dm_axi_master.sv
// CPU data-memory port to single-beat AXI4 master bridge.
// Optional sticky bus-error reporting is enabled by defining DM_AXI_BUS_ERR_EN.
module dm_axi_master #(
  parameter int unsigned     ID_W   = 4,
  parameter logic [ID_W-1:0] MST_ID = ID_W'(1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DM_ren,
  input  logic [3:0]  DM_wen,
  input  logic [31:0] DM_addr,
  input  logic [31:0] DM_wdata,
  output logic [31:0] DM_rdata,
  output logic        waiting,
  output logic        bus_err,
  dm_axi_master_if.master axi
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RADDR,
    S_RDATA,
    S_WREQ,
    S_WRESP,
    S_DONE
  } state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rdata_q;
  logic        arvalid_q;
  logic        rready_q;
  logic        awvalid_q;
  logic        wvalid_q;
  logic        bready_q;
  logic        aw_done_q;
  logic        w_done_q;

  logic        req_w;
  logic        req_r;
  logic        aw_hs;
  logic        w_hs;

  // Request decode: a store wins over a simultaneous load.
  assign req_w = (DM_wen != 4'hF);
  assign req_r = DM_ren & ~req_w;
  assign aw_hs = awvalid_q & axi.AWREADY;
  assign w_hs  = wvalid_q & axi.WREADY;

  // Hold the pipeline from request acceptance until the DONE cycle.
  assign waiting = (state_q == S_IDLE) ? (req_w | req_r) : (state_q != S_DONE);

  // Main transaction FSM with registered channel controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_w | req_r) begin
            addr_q  <= {DM_addr[31:2], 2'b00};
            wdata_q <= DM_wdata;
            wstrb_q <= ~DM_wen;
          end
          if (req_w) begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= S_WREQ;
          end else if (req_r) begin
            arvalid_q <= 1'b1;
            state_q   <= S_RADDR;
          end
        end
        S_RADDR: begin
          if (axi.ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (axi.RVALID) begin
            rdata_q  <= axi.RDATA;
            rready_q <= 1'b0;
            state_q  <= S_DONE;
          end
        end
        S_WREQ: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bready_q  <= 1'b1;
            state_q   <= S_WRESP;
          end
        end
        S_WRESP: begin
          if (axi.BVALID) begin
            bready_q <= 1'b0;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Channel output mapping; burst fields are fixed for single 32-bit beats.
  assign axi.ARID    = MST_ID;
  assign axi.ARADDR  = addr_q;
  assign axi.ARLEN   = 4'd0;
  assign axi.ARSIZE  = 3'b010;
  assign axi.ARBURST = 2'b01;
  assign axi.ARVALID = arvalid_q;
  assign axi.RREADY  = rready_q;
  assign axi.AWID    = MST_ID;
  assign axi.AWADDR  = addr_q;
  assign axi.AWLEN   = 4'd0;
  assign axi.AWSIZE  = 3'b010;
  assign axi.AWBURST = 2'b01;
  assign axi.AWVALID = awvalid_q;
  assign axi.WDATA   = wdata_q;
  assign axi.WSTRB   = wstrb_q;
  assign axi.WLAST   = 1'b1;
  assign axi.WVALID  = wvalid_q;
  assign axi.BREADY  = bready_q;
  assign DM_rdata    = rdata_q;

`ifdef DM_AXI_BUS_ERR_EN
  logic bus_err_q;
  logic unused_sigs;

  // Sticky error on any non-OKAY read or write response.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_err_q <= 1'b0;
    end else if ((state_q == S_RDATA && rready_q && axi.RVALID && axi.RRESP != 2'b00) ||
                 (state_q == S_WRESP && bready_q && axi.BVALID && axi.BRESP != 2'b00)) begin
      bus_err_q <= 1'b1;
    end
  end

  assign bus_err     = bus_err_q;
  assign unused_sigs = ^{axi.RID, axi.RLAST, axi.BID, DM_addr[1:0]};
`else
  logic unused_sigs;

  // Error reporting disabled: responses are not inspected.
  assign bus_err     = 1'b0;
  assign unused_sigs = ^{axi.RID, axi.RLAST, axi.BID, axi.RRESP, axi.BRESP, DM_addr[1:0]};
`endif

endmodule

// File: tb/tb_dm_axi_master.sv
// Directed self-checking bench for dm_axi_master.
module tb_dm_axi_master;

  logic        clk;
  logic        rst;
  logic        DM_ren;
  logic [3:0]  DM_wen;
  logic [31:0] DM_addr;
  logic [31:0] DM_wdata;
  logic [31:0] DM_rdata;
  logic        waiting;
  logic        bus_err;

  int checks;
  int errors;

  dm_axi_master_if #(.ID_W(4)) axi ();

  dm_axi_master #(.ID_W(4), .MST_ID(4'd1)) dut (
    .clk      (clk),
    .rst      (rst),
    .DM_ren   (DM_ren),
    .DM_wen   (DM_wen),
    .DM_addr  (DM_addr),
    .DM_wdata (DM_wdata),
    .DM_rdata (DM_rdata),
    .waiting  (waiting),
    .bus_err  (bus_err),
    .axi      (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_idle();
    axi.ARREADY = 1'b0;
    axi.RVALID  = 1'b0;
    axi.RDATA   = 32'h0;
    axi.RRESP   = 2'b00;
    axi.RID     = 4'd0;
    axi.RLAST   = 1'b1;
    axi.AWREADY = 1'b0;
    axi.WREADY  = 1'b0;
    axi.BVALID  = 1'b0;
    axi.BRESP   = 2'b00;
    axi.BID     = 4'd0;
  endtask

  task automatic cpu_idle();
    DM_ren   = 1'b0;
    DM_wen   = 4'hF;
    DM_addr  = 32'h0;
    DM_wdata = 32'h0;
  endtask

  // Run one transfer against an always-ready slave; reports what was observed.
  task automatic run_xfer(input logic ren, input logic [3:0] wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input logic [1:0] rresp, input logic [1:0] bresp,
                          output int cycles, output logic ar_seen, output logic aw_seen,
                          output logic [3:0] strb_seen);
    axi.ARREADY = 1'b1;
    axi.RVALID  = 1'b1;
    axi.RDATA   = rdata;
    axi.RRESP   = rresp;
    axi.AWREADY = 1'b1;
    axi.WREADY  = 1'b1;
    axi.BVALID  = 1'b1;
    axi.BRESP   = bresp;
    DM_ren   = ren;
    DM_wen   = wen;
    DM_addr  = addr;
    DM_wdata = wdata;
    cycles    = 0;
    ar_seen   = 1'b0;
    aw_seen   = 1'b0;
    strb_seen = 4'h0;
    #1;
    while (waiting && cycles < 20) begin
      tick();
      cycles++;
      if (axi.ARVALID) ar_seen = 1'b1;
      if (axi.AWVALID) begin
        aw_seen   = 1'b1;
        strb_seen = axi.WSTRB;
      end
    end
    cpu_idle();
    slave_idle();
    tick();
  endtask

  task automatic test_reset();
    cpu_idle();
    slave_idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (axi.ARVALID !== 1'b0) begin errors++; $display("FAIL reset_arvalid got %0b exp 0", axi.ARVALID); end
    checks++; if (axi.AWVALID !== 1'b0 || axi.WVALID !== 1'b0) begin errors++; $display("FAIL reset_aw_w_valid got %0b%0b exp 00", axi.AWVALID, axi.WVALID); end
    checks++; if (axi.RREADY !== 1'b0 || axi.BREADY !== 1'b0) begin errors++; $display("FAIL reset_readies got %0b%0b exp 00", axi.RREADY, axi.BREADY); end
    checks++; if (axi.ARADDR !== 32'h0 || axi.WDATA !== 32'h0 || axi.WSTRB !== 4'h0) begin errors++; $display("FAIL reset_regs got %h %h %h exp 0", axi.ARADDR, axi.WDATA, axi.WSTRB); end
    checks++; if (DM_rdata !== 32'h0 || waiting !== 1'b0 || bus_err !== 1'b0) begin errors++; $display("FAIL reset_cpu_side got %h %0b %0b exp 0 0 0", DM_rdata, waiting, bus_err); end
    checks++; if (axi.ARLEN !== 4'd0 || axi.ARSIZE !== 3'b010 || axi.ARBURST !== 2'b01 || axi.ARID !== 4'd1 || axi.WLAST !== 1'b1) begin
      errors++; $display("FAIL const_fields got len %h size %b burst %b id %h wlast %b", axi.ARLEN, axi.ARSIZE, axi.ARBURST, axi.ARID, axi.WLAST);
    end
  endtask

  task automatic test_load();
    axi.ARREADY = 1'b1;
    axi.RVALID  = 1'b1;
    axi.RDATA   = 32'hDEADBEEF;
    DM_ren  = 1'b1;
    DM_addr = 32'h0001_0006;
    #1;
    checks++; if (waiting !== 1'b1) begin errors++; $display("FAIL load_wait_c0 got %0b exp 1", waiting); end
    tick();
    checks++; if (axi.ARVALID !== 1'b1 || axi.ARADDR !== 32'h0001_0004) begin errors++; $display("FAIL load_raddr got %0b %h exp 1 00010004", axi.ARVALID, axi.ARADDR); end
    checks++; if (waiting !== 1'b1) begin errors++; $display("FAIL load_wait_c1 got %0b exp 1", waiting); end
    tick();
    checks++; if (axi.RREADY !== 1'b1 || axi.ARVALID !== 1'b0 || waiting !== 1'b1) begin errors++; $display("FAIL load_rdata got rready %0b arvalid %0b wait %0b exp 1 0 1", axi.RREADY, axi.ARVALID, waiting); end
    tick();
    checks++; if (waiting !== 1'b0 || DM_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL load_done got wait %0b data %h exp 0 deadbeef", waiting, DM_rdata); end
    checks++; if (axi.RREADY !== 1'b0) begin errors++; $display("FAIL load_done_rready got %0b exp 0", axi.RREADY); end
    tick();
    checks++; if (axi.ARVALID !== 1'b0) begin errors++; $display("FAIL load_no_reissue got %0b exp 0", axi.ARVALID); end
    cpu_idle();
    slave_idle();
    #1;
    checks++; if (waiting !== 1'b0) begin errors++; $display("FAIL idle_wait got %0b exp 0", waiting); end
    tick();
  endtask

  task automatic test_store();
    int aw_cycles;
    aw_cycles = 0;
    axi.WREADY = 1'b1;
    DM_wen   = 4'b1100;
    DM_wdata = 32'h0000_1234;
    DM_addr  = 32'h0000_0020;
    #1;
    checks++; if (waiting !== 1'b1) begin errors++; $display("FAIL store_wait_c0 got %0b exp 1", waiting); end
    tick();
    checks++; if (axi.AWVALID !== 1'b1 || axi.WVALID !== 1'b1) begin errors++; $display("FAIL store_valids got %0b%0b exp 11", axi.AWVALID, axi.WVALID); end
    checks++; if (axi.WSTRB !== 4'b0011 || axi.WDATA !== 32'h0000_1234 || axi.AWADDR !== 32'h0000_0020) begin errors++; $display("FAIL store_payload got %b %h %h exp 0011 00001234 00000020", axi.WSTRB, axi.WDATA, axi.AWADDR); end
    aw_cycles++;
    tick();
    checks++; if (axi.WVALID !== 1'b0 || axi.AWVALID !== 1'b1) begin errors++; $display("FAIL store_w_drop got wv %0b awv %0b exp 0 1", axi.WVALID, axi.AWVALID); end
    aw_cycles++;
    tick();
    if (axi.AWVALID === 1'b1) aw_cycles++;
    axi.AWREADY = 1'b1;
    tick();
    axi.AWREADY = 1'b0;
    checks++; if (aw_cycles !== 3 || axi.AWVALID !== 1'b0) begin errors++; $display("FAIL store_aw_hold got %0d cycles awv %0b exp 3 0", aw_cycles, axi.AWVALID); end
    checks++; if (axi.BREADY !== 1'b1 || waiting !== 1'b1) begin errors++; $display("FAIL store_wresp got bready %0b wait %0b exp 1 1", axi.BREADY, waiting); end
    axi.BVALID = 1'b1;
    tick();
    checks++; if (waiting !== 1'b0 || axi.BREADY !== 1'b0) begin errors++; $display("FAIL store_done got wait %0b bready %0b exp 0 0", waiting, axi.BREADY); end
    checks++; if (DM_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL store_rdata_hold got %h exp deadbeef", DM_rdata); end
    cpu_idle();
    slave_idle();
    tick();
  endtask

  task automatic test_priority();
    int cyc;
    logic ar_s, aw_s;
    logic [3:0] strb;
    run_xfer(1'b1, 4'b0000, 32'h0000_0100, 32'hA5A5_5A5A, 32'h0, 2'b00, 2'b00, cyc, ar_s, aw_s, strb);
    checks++; if (ar_s !== 1'b0) begin errors++; $display("FAIL prio_no_ar got %0b exp 0", ar_s); end
    checks++; if (aw_s !== 1'b1 || strb !== 4'hF) begin errors++; $display("FAIL prio_write got aw %0b strb %b exp 1 1111", aw_s, strb); end
    checks++; if (cyc !== 3) begin errors++; $display("FAIL prio_latency got %0d exp 3", cyc); end
  endtask

  task automatic test_slow_load();
    DM_ren  = 1'b1;
    DM_addr = 32'h1000_000B;
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++; if (axi.ARVALID !== 1'b1 || axi.ARADDR !== 32'h1000_0008) begin errors++; $display("FAIL slow_ar_stable[%0d] got %0b %h exp 1 10000008", i, axi.ARVALID, axi.ARADDR); end
      tick();
    end
    axi.ARREADY = 1'b1;
    tick();
    axi.ARREADY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (axi.RREADY !== 1'b1 || waiting !== 1'b1) begin errors++; $display("FAIL slow_rwait[%0d] got rready %0b wait %0b exp 1 1", i, axi.RREADY, waiting); end
      tick();
    end
    axi.RVALID = 1'b1;
    axi.RDATA  = 32'hCAFE_F00D;
    tick();
    checks++; if (waiting !== 1'b0 || DM_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL slow_done got wait %0b data %h exp 0 cafef00d", waiting, DM_rdata); end
    cpu_idle();
    slave_idle();
    tick();
  endtask

  task automatic test_rst_mid();
    axi.ARREADY = 1'b1;
    DM_ren  = 1'b1;
    DM_addr = 32'h0000_0040;
    tick();
    tick();
    checks++; if (axi.RREADY !== 1'b1) begin errors++; $display("FAIL rst_pre_rdata got %0b exp 1", axi.RREADY); end
    rst = 1'b1;
    cpu_idle();
    slave_idle();
    tick();
    rst = 1'b0;
    checks++; if (axi.ARVALID !== 1'b0 || axi.RREADY !== 1'b0 || axi.AWVALID !== 1'b0 || axi.WVALID !== 1'b0 || axi.BREADY !== 1'b0) begin
      errors++; $display("FAIL rst_mid_handshake got ar %0b r %0b aw %0b w %0b b %0b exp 0", axi.ARVALID, axi.RREADY, axi.AWVALID, axi.WVALID, axi.BREADY);
    end
    checks++; if (waiting !== 1'b0 || DM_rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_cpu got wait %0b data %h exp 0 0", waiting, DM_rdata); end
    tick();
  endtask

  task automatic test_bus_err();
    int cyc;
    logic ar_s, aw_s;
    logic [3:0] strb;
    logic exp_err;
`ifdef DM_AXI_BUS_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    run_xfer(1'b0, 4'b0000, 32'h0000_0200, 32'h1111_2222, 32'h0, 2'b00, 2'b10, cyc, ar_s, aw_s, strb);
    checks++; if (bus_err !== exp_err) begin errors++; $display("FAIL err_after_store got %0b exp %0b", bus_err, exp_err); end
    for (int i = 0; i < 3; i++) begin
      run_xfer(1'b1, 4'hF, 32'h0000_0300 + 32'(i * 4), 32'h0, 32'h5000_0000 + 32'(i), 2'b00, 2'b00, cyc, ar_s, aw_s, strb);
      checks++; if (DM_rdata !== 32'h5000_0000 + 32'(i) || cyc !== 3) begin errors++; $display("FAIL err_load[%0d] got %h cyc %0d exp %h 3", i, DM_rdata, cyc, 32'h5000_0000 + 32'(i)); end
    end
    checks++; if (bus_err !== exp_err) begin errors++; $display("FAIL err_sticky got %0b exp %0b", bus_err, exp_err); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    test_reset();
    test_load();
    test_store();
    test_priority();
    test_slow_load();
    test_rst_mid();
    test_bus_err();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_axi_master.md
Name: dm_axi_master

Overview:
- Bridges the CPU data-memory port (DM_* signals plus `waiting`) onto a single-beat AXI4 master interface.
- Sits directly downstream of the CPU core in the CPU wrapper. It consumes the CPU's EXE-stage load/store requests, holds the pipeline through `waiting` until the bus completes, and returns load data for the MEM_WB capture.

Parameters:
ID_W, 4, width of ARID/AWID/RID/BID
MST_ID, 4'd1, constant ID driven on ARID/AWID

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
DM_ren  input  1  load request
DM_wen  input  4  active-low byte write enables; 4'hF = no store
DM_addr  input  32  byte address
DM_wdata  input  32  lane-aligned store data
DM_rdata  output  32  load word, valid when waiting=0 after a load
waiting  output  1  pipeline hold
bus_err  output  1  sticky error flag (see Optional Feature)
ARID/ARADDR  output  ID_W/32  read address channel
ARLEN/ARSIZE/ARBURST  output  4/3/2  constants 0 / 3'b010 / 2'b01
ARVALID  output  1 ; ARREADY  input  1
RID/RDATA/RRESP/RLAST  input  ID_W/32/2/1  read data channel
RVALID  input  1 ; RREADY  output  1
AWID/AWADDR  output  ID_W/32  write address channel
AWLEN/AWSIZE/AWBURST  output  4/3/2  constants 0 / 3'b010 / 2'b01
AWVALID  output  1 ; AWREADY  input  1
WDATA/WSTRB/WLAST  output  32/4/1  write data; WLAST tied 1
WVALID  output  1 ; WREADY  input  1
BID/BRESP  input  ID_W/2  write response
BVALID  input  1 ; BREADY  output  1

Behaviour:
- States: IDLE, RADDR, RDATA, WREQ, WRESP, DONE. Reset puts the FSM in IDLE.
- Reset values: all VALID/READY outputs 0, ARADDR/AWADDR/WDATA 0, WSTRB 0, DM_rdata 0, bus_err 0.
- Request detection: req_w = (DM_wen != 4'hF); req_r = DM_ren & ~req_w. A store takes priority if both are asserted.
- IDLE with a request:
  - waiting=1 combinationally in that same cycle.
  - Latch {DM_addr[31:2],2'b00}, DM_wdata, WSTRB=~DM_wen.
  - Go to RADDR (load) or WREQ (store).
- IDLE without a request: waiting=0.
- RADDR: ARVALID=1 and held stable until ARREADY. On handshake, go to RDATA.
- RDATA: RREADY=1. On RVALID, register RDATA into DM_rdata and go to DONE. RID and RLAST are ignored.
- WREQ:
  - AWVALID and WVALID are asserted in the same cycle.
  - Each handshake is tracked by its own done flag and the matching VALID drops after it.
  - The AW and W handshakes may complete in either order or the same cycle.
  - When both are done, go to WRESP.
- WRESP: BREADY=1. On BVALID, go to DONE.
- waiting=1 in RADDR, RDATA, WREQ and WRESP.
- DONE:
  - waiting=0 and DM_rdata holds the load word.
  - The request still presented by the CPU this cycle is NOT reissued. The next state is IDLE unconditionally.
- Minimum latency with ready slaves:
  - Load: 4 cycles (IDLE→RADDR→RDATA→DONE).
  - Store: 4 cycles (IDLE→WREQ→WRESP→DONE).
- VALID never depends combinationally on READY. The address and data lines stay stable while VALID=1.
- Reset mid-transaction: the FSM returns to IDLE immediately, all VALIDs drop, and the in-flight transaction is abandoned. The slave is reset by the same rst.
- DM_rdata keeps its last value across stores and idle cycles.

Optional Feature:
- Macro: DM_AXI_BUS_ERR_EN.
- Defined:
  - bus_err sets to 1 on any R handshake with RRESP!=2'b00, or any B handshake with BRESP!=2'b00.
  - It stays set until rst.
  - Load data is still returned on an error.
- Undefined: bus_err is tied to 0 and RRESP/BRESP are ignored.

Test Plan:
- Load, ARREADY/RVALID immediately high, RDATA=32'hDEADBEEF, DM_addr=32'h0001_0006 → ARADDR=32'h0001_0004, waiting high for 3 cycles, DM_rdata=32'hDEADBEEF with waiting=0 in the 4th cycle.
- Store DM_wen=4'b1100, DM_wdata=32'h0000_1234, AWREADY 2 cycles late, WREADY immediate → WSTRB=4'b0011, WVALID drops after 1 cycle, AWVALID is held 3 cycles, B completes, waiting falls.
- DM_ren=1 with DM_wen=4'b0000 in the same cycle → only a write issued, ARVALID never asserted.
- Load with RVALID delayed 5 cycles → RREADY high and waiting high throughout; ARADDR stable while ARVALID=1.
- rst asserted during RDATA → next cycle: state IDLE, all VALID/READY=0, waiting=0 with no request, DM_rdata=0.
- With DM_AXI_BUS_ERR_EN: store with BRESP=2'b10 → bus_err=1 and it remains 1 after 3 further clean loads. Without the macro: bus_err stays 0.
